// File: rtl/ibex_rvfi_trace_fifo.sv
// RVFI retirement-trace capture FIFO: first-word-fall-through record buffer with drop
// accounting, gap marking and rvfi_order continuity checking.
module ibex_rvfi_trace_fifo #(
  parameter int unsigned Depth        = 16,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic                      rvfi_valid,
  input  logic [63:0]               rvfi_order,
  input  logic [31:0]               rvfi_pc_rdata,
  input  logic [31:0]               rvfi_insn,
  input  logic                      rvfi_trap,
  input  logic [4:0]                rvfi_rd_addr,
  input  logic [31:0]               rvfi_rd_wdata,
  input  logic [31:0]               rvfi_mem_addr,
  input  logic [3:0]                rvfi_mem_rmask,
  input  logic [3:0]                rvfi_mem_wmask,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output logic [63:0]               trace_order_o,
  output logic [31:0]               trace_pc_o,
  output logic [31:0]               trace_insn_o,
  output logic                      trace_trap_o,
  output logic [4:0]                trace_rd_addr_o,
  output logic [31:0]               trace_rd_wdata_o,
  output logic [31:0]               trace_mem_addr_o,
  output logic [3:0]                trace_mem_rmask_o,
  output logic [3:0]                trace_mem_wmask_o,
  output logic                      trace_gap_o,
  output logic [$clog2(Depth):0]    level_o,
  output logic [DropCntWidth-1:0]   drop_cnt_o,
  output logic                      overflow_o,
  output logic                      seq_err_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic        gap;
  } rec_t;

  rec_t                    mem_q [Depth];
  rec_t                    head;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [DropCntWidth-1:0] drop_cnt_q;
  logic                    overflow_q, seq_err_q, gap_pending_q, order_seen_q;
  logic [63:0]             last_order_q;
  logic                    empty, full, push, pop, drop, seq_mismatch;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same slot index but opposite wrap bit means the writer is a full lap ahead.
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign pop  = trace_valid_o & trace_ready_i;
  assign push = rvfi_valid & enable_i & (~full | pop);
  assign drop = rvfi_valid & enable_i & full & ~pop;

  assign seq_mismatch = order_seen_q && (rvfi_order != last_order_q + 64'd1);

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= '{
        order:     rvfi_order,
        pc:        rvfi_pc_rdata,
        insn:      rvfi_insn,
        trap:      rvfi_trap,
        rd_addr:   rvfi_rd_addr,
        rd_wdata:  rvfi_rd_wdata,
        mem_addr:  rvfi_mem_addr,
        mem_rmask: rvfi_mem_rmask,
        mem_wmask: rvfi_mem_wmask,
        gap:       gap_pending_q
      };
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      gap_pending_q <= 1'b0;
      order_seen_q  <= 1'b0;
      last_order_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      gap_pending_q <= 1'b0;
      order_seen_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q      <= wr_ptr_q + PtrW'(1);
        gap_pending_q <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (drop) begin
        gap_pending_q <= 1'b1;
        overflow_q    <= 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + DropCntWidth'(1);
        end
      end
      // Continuity is tracked on every retirement, even ones not stored.
      if (rvfi_valid) begin
        if (seq_mismatch) begin
          seq_err_q <= 1'b1;
        end
        last_order_q <= rvfi_order;
        order_seen_q <= 1'b1;
      end
    end
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

  assign trace_valid_o     = ~empty;
  assign trace_order_o     = head.order;
  assign trace_pc_o        = head.pc;
  assign trace_insn_o      = head.insn;
  assign trace_trap_o      = head.trap;
  assign trace_rd_addr_o   = head.rd_addr;
  assign trace_rd_wdata_o  = head.rd_wdata;
  assign trace_mem_addr_o  = head.mem_addr;
  assign trace_mem_rmask_o = head.mem_rmask;
  assign trace_mem_wmask_o = head.mem_wmask;
  assign trace_gap_o       = head.gap;

  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;
  assign seq_err_o  = seq_err_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
// Randomized bench for ibex_rvfi_trace_fifo against a queue-based model; a second
// instance with a 2-bit drop counter exercises saturation on the same stimulus.
module tb_ibex_rvfi_trace_fifo;

  localparam int Depth = 16;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic        gap;
  } tb_rec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni, enable_i, flush_i, rvfi_valid, rvfi_trap, trace_ready_i;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr;
  logic [4:0]  rvfi_rd_addr;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

  logic        trace_valid_o, trace_trap_o, trace_gap_o, overflow_o, seq_err_o;
  logic [63:0] trace_order_o;
  logic [31:0] trace_pc_o, trace_insn_o, trace_rd_wdata_o, trace_mem_addr_o;
  logic [4:0]  trace_rd_addr_o;
  logic [3:0]  trace_mem_rmask_o, trace_mem_wmask_o;
  logic [4:0]  level_o;
  logic [15:0] drop_cnt_o;

  logic        s_valid, s_trap, s_gap, s_overflow, s_seq_err;
  logic [63:0] s_order;
  logic [31:0] s_pc, s_insn, s_rd_wdata, s_mem_addr;
  logic [4:0]  s_rd_addr, s_level;
  logic [3:0]  s_rmask, s_wmask;
  logic [1:0]  s_drop_cnt;

  ibex_rvfi_trace_fifo #(.Depth(Depth), .DropCntWidth(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_order_o(trace_order_o), .trace_pc_o(trace_pc_o), .trace_insn_o(trace_insn_o),
    .trace_trap_o(trace_trap_o), .trace_rd_addr_o(trace_rd_addr_o),
    .trace_rd_wdata_o(trace_rd_wdata_o), .trace_mem_addr_o(trace_mem_addr_o),
    .trace_mem_rmask_o(trace_mem_rmask_o), .trace_mem_wmask_o(trace_mem_wmask_o),
    .trace_gap_o(trace_gap_o), .level_o(level_o), .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o), .seq_err_o(seq_err_o)
  );

  ibex_rvfi_trace_fifo #(.Depth(Depth), .DropCntWidth(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(s_valid), .trace_ready_i(trace_ready_i),
    .trace_order_o(s_order), .trace_pc_o(s_pc), .trace_insn_o(s_insn),
    .trace_trap_o(s_trap), .trace_rd_addr_o(s_rd_addr), .trace_rd_wdata_o(s_rd_wdata),
    .trace_mem_addr_o(s_mem_addr), .trace_mem_rmask_o(s_rmask),
    .trace_mem_wmask_o(s_wmask), .trace_gap_o(s_gap), .level_o(s_level),
    .drop_cnt_o(s_drop_cnt), .overflow_o(s_overflow), .seq_err_o(s_seq_err)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  tb_rec_t     m_q[$];
  int          m_drops;
  bit          m_gap, m_ovf, m_seq_err, m_seen;
  logic [63:0] m_last;
  logic [63:0] next_order;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_q.delete();
    m_drops   = 0;
    m_gap     = 0;
    m_ovf     = 0;
    m_seq_err = 0;
    m_seen    = 0;
  endfunction

  // Applies one clock edge worth of behaviour to the model from the current inputs.
  function automatic void model_step();
    tb_rec_t r;
    bit      pop, full;
    if (flush_i) begin
      model_clear();
      return;
    end
    pop  = (m_q.size() != 0) && trace_ready_i;
    full = (m_q.size() == Depth);
    if (pop) void'(m_q.pop_front());
    if (rvfi_valid && enable_i) begin
      if (!full || pop) begin
        r = '{rvfi_order, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_rd_addr, rvfi_rd_wdata,
              rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, m_gap};
        m_q.push_back(r);
        m_gap = 0;
      end else begin
        m_drops++;
        m_ovf = 1;
        m_gap = 1;
      end
    end
    if (rvfi_valid) begin
      if (m_seen && rvfi_order != m_last + 64'd1) m_seq_err = 1;
      m_last = rvfi_order;
      m_seen = 1;
    end
  endfunction

  task automatic check_all();
    tb_rec_t exp_r;
    int      sat16, sat2;
    exp_r = (m_q.size() != 0) ? m_q[0] : '0;
    sat16 = (m_drops > 65535) ? 65535 : m_drops;
    sat2  = (m_drops > 3) ? 3 : m_drops;
    check_eq("valid", 256'(trace_valid_o), 256'(m_q.size() != 0));
    check_eq("head", 256'({trace_order_o, trace_pc_o, trace_insn_o, trace_trap_o,
                           trace_rd_addr_o, trace_rd_wdata_o, trace_mem_addr_o,
                           trace_mem_rmask_o, trace_mem_wmask_o, trace_gap_o}), 256'(exp_r));
    check_eq("level", 256'(level_o), 256'(m_q.size()));
    check_eq("drop_cnt", 256'(drop_cnt_o), 256'(sat16));
    check_eq("drop_cnt_sat", 256'(s_drop_cnt), 256'(sat2));
    check_eq("overflow", 256'(overflow_o), 256'(m_ovf));
    check_eq("seq_err", 256'(seq_err_o), 256'(m_seq_err));
  endtask

  task automatic cycle(input logic v, input logic [63:0] ord, input logic [31:0] pc,
                       input logic rdy);
    rvfi_valid     = v;
    rvfi_order     = ord;
    rvfi_pc_rdata  = pc;
    rvfi_insn      = $urandom;
    rvfi_trap      = 1'($urandom);
    rvfi_rd_addr   = 5'($urandom);
    rvfi_rd_wdata  = $urandom;
    rvfi_mem_addr  = $urandom;
    rvfi_mem_rmask = 4'($urandom);
    rvfi_mem_wmask = 4'($urandom);
    trace_ready_i  = rdy;
    model_step();
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic retire(input logic rdy);
    cycle(1'b1, next_order, $urandom, rdy);
    next_order = next_order + 64'd1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    cycle(1'b0, 64'd0, 32'd0, 1'b0);
    flush_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; flush_i = 1'b0; rvfi_valid = 1'b0; trace_ready_i = 1'b0;
    rvfi_order = '0; rvfi_pc_rdata = '0; rvfi_insn = '0; rvfi_trap = 1'b0; rvfi_rd_addr = '0;
    rvfi_rd_wdata = '0; rvfi_mem_addr = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
    model_clear();
    m_last = '0;
    #3;
    check_all();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Basic flow: each record visible one cycle after capture, drained straight away
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'(i + 1), 32'h100 + 32'(4 * i), 1'b1);
      check_eq("basic_pc", 256'(trace_pc_o), 256'(32'h100 + 32'(4 * i)));
    end
    cycle(1'b0, 64'd0, 32'd0, 1'b1);
    do_flush();

    // Overflow: 20 retirements into a stalled sink, then drain with order 21
    next_order = 64'd1;
    for (int i = 0; i < 20; i++) retire(1'b0);
    check_eq("ovf_level", 256'(level_o), 256'(16));
    check_eq("ovf_drops", 256'(drop_cnt_o), 256'(4));
    check_eq("ovf_flag", 256'(overflow_o), 256'(1));
    retire(1'b1);
    for (int i = 0; i < 20 && trace_order_o != 64'd21; i++) cycle(1'b0, 64'd0, 32'd0, 1'b1);
    check_eq("gap_order", 256'(trace_order_o), 256'(21));
    check_eq("gap_flag", 256'(trace_gap_o), 256'(1));
    do_flush();

    // Full with simultaneous pop and push
    next_order = 64'd100;
    for (int i = 0; i < 16; i++) retire(1'b0);
    retire(1'b1);
    check_eq("full_pp_level", 256'(level_o), 256'(16));
    check_eq("full_pp_drops", 256'(drop_cnt_o), 256'(0));
    do_flush();

    // Sequence error, enabled then disabled
    for (int e = 1; e >= 0; e--) begin
      enable_i = 1'(e);
      cycle(1'b1, 64'd5, $urandom, 1'b0);
      cycle(1'b1, 64'd6, $urandom, 1'b0);
      check_eq("seq_ok", 256'(seq_err_o), 256'(0));
      cycle(1'b1, 64'd8, $urandom, 1'b0);
      check_eq("seq_err", 256'(seq_err_o), 256'(1));
      cycle(1'b0, 64'd0, 32'd0, 1'b0);
      check_eq("seq_sticky", 256'(seq_err_o), 256'(1));
      do_flush();
    end
    check_eq("seq_dis_level", 256'(level_o), 256'(0));
    enable_i = 1'b1;

    // Flush with 7 held records, 3 drops and a retirement in the same cycle
    next_order = 64'd200;
    for (int i = 0; i < 19; i++) retire(1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 64'd0, 32'd0, 1'b1);
    check_eq("pre_flush_level", 256'(level_o), 256'(7));
    check_eq("pre_flush_drops", 256'(drop_cnt_o), 256'(3));
    flush_i = 1'b1;
    retire(1'b0);
    flush_i = 1'b0;
    check_eq("flush_level", 256'(level_o), 256'(0));
    check_eq("flush_valid", 256'(trace_valid_o), 256'(0));

    // Saturation: 6 drops
    for (int i = 0; i < 22; i++) retire(1'b0);
    check_eq("sat_cnt2", 256'(s_drop_cnt), 256'(3));
    check_eq("sat_cnt16", 256'(drop_cnt_o), 256'(6));

    // Asynchronous reset mid-drain
    retire(1'b1);
    #2 rst_ni = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    rvfi_valid = 1'b0;

    // Randomized traffic
    next_order = 64'($urandom);
    for (int i = 0; i < 600; i++) begin
      enable_i = ($urandom_range(0, 7) != 0);
      flush_i  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 40) == 0) next_order = next_order + 64'($urandom_range(2, 9));
        cycle(1'b1, next_order, $urandom, ((i / 40) % 2 == 0) ? 1'b1 : 1'($urandom));
        next_order = next_order + 64'd1;
      end else begin
        cycle(1'b0, 64'($urandom), $urandom, 1'($urandom));
      end
    end
    flush_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
